rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port (wb_enable/wb_rd/reg_write_data into the ID-stage regfile)

---
 rtl/rf_write_arbiter_pkg.sv | 13 +
 rtl/rf_wr_fifo.sv | 66 ++++++
 rtl/rf_write_arbiter.sv | 116 +++++++++++
 tb/tb_rf_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 32;
  localparam int RF_XLEN   = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_XLEN-1:0]   data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Circular buffer of pending side writes; exposes per-entry valid/rd taps for the busy vector.
module rf_wr_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  rf_wr_req_t                            push_req,
  input  logic                                  pop,
  output rf_wr_req_t                            head,
  output logic [$clog2(DEPTH+1)-1:0]            count,
  output logic [DEPTH-1:0]                      entry_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]       entry_rd
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_wr_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The caller never pops when empty nor pushes when full, so push and pop
  // never target the same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; entry_valid alone decides
  // whether a slot means anything, so the RAM needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head = mem[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    assign entry_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between WB (always wins) and a queued side requester.
// Optional build macro RF_ARB_BYPASS_EN: side write goes straight to the port when queue empty and WB idle.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = RF_XLEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_we,
  input  logic [RF_ADDR_W-1:0]       pipe_rd,
  input  logic [XLEN-1:0]            pipe_data,
  input  logic                       side_valid,
  output logic                       side_ready,
  input  logic [RF_ADDR_W-1:0]       side_rd,
  input  logic [XLEN-1:0]            side_data,
  output logic                       wb_enable,
  output logic [RF_ADDR_W-1:0]       wb_rd,
  output logic [XLEN-1:0]            reg_write_data,
  output logic [RF_NREGS-1:0]        busy,
  output logic                       stall_req,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  rf_wr_req_t                      head;
  rf_wr_req_t                      push_req;
  logic [DEPTH-1:0]                entry_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0] entry_rd;
  logic                            pipe_act;
  logic                            fifo_empty;
  logic                            side_acc;
  logic                            bypass;
  logic                            push;
  logic                            pop;
  logic                            waiting;
  logic [SC_W-1:0]                 starve_cnt;

  assign pipe_act   = pipe_we && (pipe_rd != '0);
  assign fifo_empty = (fifo_count == '0);
  // Ready comes from the registered count only: a same-cycle pop never frees a slot.
  assign side_ready = (fifo_count != CNT_W'(DEPTH));
  assign side_acc   = side_valid && side_ready && (side_rd != '0);

`ifdef RF_ARB_BYPASS_EN
  assign bypass = side_acc && fifo_empty && !pipe_act;
`else
  assign bypass = 1'b0;
`endif

  assign pop      = !pipe_act && !fifo_empty;
  assign push     = side_acc && !bypass;
  assign waiting  = !fifo_empty && !pop;
  assign push_req = '{rd: side_rd, data: side_data};

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_req    (push_req),
    .pop         (pop),
    .head        (head),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_enable      = 1'b0;
    wb_rd          = '0;
    reg_write_data = '0;
    if (pipe_act) begin
      wb_enable      = 1'b1;
      wb_rd          = pipe_rd;
      reg_write_data = pipe_data;
    end else if (!fifo_empty) begin
      wb_enable      = 1'b1;
      wb_rd          = head.rd;
      reg_write_data = head.data;
    end else if (bypass) begin
      wb_enable      = 1'b1;
      wb_rd          = side_rd;
      reg_write_data = side_data;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy[entry_rd[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  // Counter saturates at the limit so a long stall cannot wrap it back below threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (!waiting)                                starve_cnt <= '0;
      else if (starve_cnt != SC_W'(STARVE_LIMIT))  starve_cnt <= starve_cnt + SC_W'(1);
      stall_req <= waiting && (int'(starve_cnt) + 1 >= STARVE_LIMIT);
    end
  end

  // The hazard unit must keep WB away from registers with a queued side write.
  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n) !(pipe_we && busy[pipe_rd]));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model plus directed scenarios.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int XLEN         = 32;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       pipe_we;
  logic [4:0]                 pipe_rd;
  logic [XLEN-1:0]            pipe_data;
  logic                       side_valid;
  logic                       side_ready;
  logic [4:0]                 side_rd;
  logic [XLEN-1:0]            side_data;
  logic                       wb_enable;
  logic [4:0]                 wb_rd;
  logic [XLEN-1:0]            reg_write_data;
  logic [31:0]                busy;
  logic                       stall_req;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  int n_cmp = 0;
  int n_mis = 0;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_we        (pipe_we),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .side_valid     (side_valid),
    .side_ready     (side_ready),
    .side_rd        (side_rd),
    .side_data      (side_data),
    .wb_enable      (wb_enable),
    .wb_rd          (wb_rd),
    .reg_write_data (reg_write_data),
    .busy           (busy),
    .stall_req      (stall_req),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of pending side writes plus the starvation history.
  rf_wr_req_t q[$];
  int         wait_cyc = 0;
  bit         stall_m  = 0;

  always @(negedge clk) begin
    logic        acc, popped, byp, waited;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_busy;
    if (!rst_n) begin
      q.delete();
      wait_cyc = 0;
      stall_m  = 0;
    end
    e_busy = '0;
    foreach (q[i]) e_busy[q[i].rd] = 1'b1;
    acc    = side_valid && (q.size() < DEPTH) && (side_rd != 5'd0);
    popped = 1'b0;
    byp    = 1'b0;
    e_en   = 1'b0;
    e_rd   = '0;
    e_data = '0;
    if (pipe_we && pipe_rd != 5'd0) begin
      e_en = 1'b1; e_rd = pipe_rd; e_data = pipe_data;
    end else if (q.size() > 0) begin
      e_en = 1'b1; e_rd = q[0].rd; e_data = q[0].data; popped = 1'b1;
    end
`ifdef RF_ARB_BYPASS_EN
    else if (acc) begin
      e_en = 1'b1; e_rd = side_rd; e_data = side_data; byp = 1'b1;
    end
`endif
    check("model.wb_enable",  64'(wb_enable),      64'(e_en));
    check("model.wb_rd",      64'(wb_rd),          64'(e_rd));
    check("model.data",       64'(reg_write_data), 64'(e_data));
    check("model.side_ready", 64'(side_ready),     64'(q.size() != DEPTH));
    check("model.fifo_count", 64'(fifo_count),     64'(q.size()));
    check("model.busy",       64'(busy),           64'(e_busy));
    check("model.stall_req",  64'(stall_req),      64'(stall_m));
    if (rst_n) begin
      waited = (q.size() > 0) && !popped;
      if (popped) void'(q.pop_front());
      if (acc && !byp) q.push_back('{rd: side_rd, data: side_data});
      stall_m  = waited && (wait_cyc + 1 >= STARVE_LIMIT);
      wait_cyc = waited ? wait_cyc + 1 : 0;
    end
  end

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic sv, input logic [4:0] srd, input logic [31:0] sd);
    @(posedge clk);
    #1;
    pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    side_valid = sv; side_rd = srd; side_data = sd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wb(input string name, input logic en, input logic [4:0] rd, input logic [31:0] d);
    check({name, ".wb_enable"}, 64'(wb_enable), 64'(en));
    check({name, ".wb_rd"},     64'(wb_rd),     64'(rd));
    check({name, ".data"},      64'(reg_write_data), 64'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    side_valid = 0; side_rd = 0; side_data = 0;
    #2;
    check("reset.fifo_count", 64'(fifo_count), 64'd0);
    check("reset.side_ready", 64'(side_ready), 64'd1);
    check("reset.stall_req",  64'(stall_req),  64'd0);
    check("reset.busy",       64'(busy),       64'd0);
    check("reset.wb_enable",  64'(wb_enable),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single side write on an idle port
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_0001);
    @(negedge clk);
`ifdef RF_ARB_BYPASS_EN
    expect_wb("t1.bypass", 1'b1, 5'd5, 32'hA5A5_0001);
    check("t1.busy_a", 64'(busy), 64'd0);
`else
    expect_wb("t1.accept", 1'b0, 5'd0, 32'd0);
`endif
    idle();
    @(negedge clk);
`ifdef RF_ARB_BYPASS_EN
    expect_wb("t1.after", 1'b0, 5'd0, 32'd0);
    check("t1.busy_b", 64'(busy), 64'd0);
`else
    expect_wb("t1.drain", 1'b1, 5'd5, 32'hA5A5_0001);
    check("t1.busy_b", 64'(busy), 64'h20);
`endif
    idle();
    @(negedge clk);
    check("t1.busy_c", 64'(busy), 64'd0);
    check("t1.count_c", 64'(fifo_count), 64'd0);

    // 2: fill behind a busy WB, third request held until a slot frees
    drive(1'b1, 5'd10, 32'h1000_0000, 1'b1, 5'd3, 32'h0000_0003);
    drive(1'b1, 5'd10, 32'h1000_0001, 1'b1, 5'd4, 32'h0000_0004);
    @(negedge clk);
    check("t2.count1", 64'(fifo_count), 64'd1);
    drive(1'b1, 5'd10, 32'h1000_0002, 1'b1, 5'd6, 32'h0000_0006);
    @(negedge clk);
    check("t2.ready_full", 64'(side_ready), 64'd0);
    check("t2.count_full", 64'(fifo_count), 64'd2);
    check("t2.busy_full",  64'(busy),       64'h18);
    drive(1'b1, 5'd10, 32'h1000_0003, 1'b1, 5'd6, 32'h0000_0006);
    @(negedge clk);
    check("t2.ready_held", 64'(side_ready), 64'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0006);
    @(negedge clk);
    expect_wb("t2.drain3", 1'b1, 5'd3, 32'h0000_0003);
    check("t2.ready_popping", 64'(side_ready), 64'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0006);
    @(negedge clk);
    check("t2.ready_freed", 64'(side_ready), 64'd1);
    expect_wb("t2.drain4", 1'b1, 5'd4, 32'h0000_0004);
    idle();
    @(negedge clk);
    expect_wb("t2.drain6", 1'b1, 5'd6, 32'h0000_0006);
    idle();

    // 3: starvation behind a continuously writing WB
    drive(1'b1, 5'd10, 32'h2000_0000, 1'b1, 5'd7, 32'h0000_0007);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd10, 32'h2000_0001 + 32'(i), 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("t3.no_stall_yet", 64'(stall_req), 64'd0);
    end
    drive(1'b1, 5'd11, 32'h2000_00FF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t3.stall_up", 64'(stall_req), 64'd1);
    expect_wb("t3.wb_wins", 1'b1, 5'd11, 32'h2000_00FF);
    idle();
    @(negedge clk);
    expect_wb("t3.head_drains", 1'b1, 5'd7, 32'h0000_0007);
    idle();
    @(negedge clk);
    check("t3.stall_down", 64'(stall_req), 64'd0);

    // 4: full FIFO with same-cycle pop refuses push; then pointer wrap with ordering
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd11, 32'h0000_0011);
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd12, 32'h0000_0012);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h0000_0013);
    @(negedge clk);
    check("t4.refused", 64'(side_ready), 64'd0);
    expect_wb("t4.pop11", 1'b1, 5'd11, 32'h0000_0011);
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd13, 32'h0000_0013);
    @(negedge clk);
    check("t4.accept_next", 64'(side_ready), 64'd1);
    check("t4.count", 64'(fifo_count), 64'd1);
    idle();
    idle();
    idle();
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd20, 32'h0000_2000);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h0000_2000 + 32'(i));
      @(negedge clk);
      expect_wb("t4.wrap", 1'b1, 5'(19 + i), 32'h0000_2000 + 32'(i - 1));
      check("t4.wrap_count", 64'(fifo_count), 64'd1);
    end
    idle();
    @(negedge clk);
    expect_wb("t4.last", 1'b1, 5'd30, 32'h0000_200A);
    idle();

    // 5: rd=0 side write is swallowed; pipe_rd=0 counts as an idle slot
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t5.ready_rd0", 64'(side_ready), 64'd1);
    expect_wb("t5.no_write", 1'b0, 5'd0, 32'd0);
    idle();
    @(negedge clk);
    check("t5.count_rd0", 64'(fifo_count), 64'd0);
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd9, 32'h0000_0009);
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    expect_wb("t5.x0_idle", 1'b1, 5'd9, 32'h0000_0009);
    idle();

    // 6: reset with two queued entries and stall_req high
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd14, 32'h0000_0014);
    drive(1'b1, 5'd10, 32'd0, 1'b1, 5'd15, 32'h0000_0015);
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd10, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t6.pre_stall", 64'(stall_req), 64'd1);
    check("t6.pre_count", 64'(fifo_count), 64'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    #1;
    check("t6.rst_count", 64'(fifo_count), 64'd0);
    check("t6.rst_busy",  64'(busy),       64'd0);
    check("t6.rst_stall", 64'(stall_req),  64'd0);
    check("t6.rst_wb",    64'(wb_enable),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6.no_stale", 64'(wb_enable), 64'd0);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
